// File: rtl/serial_paralelo_phy_rx_align_pkg.sv
// Shared PHY definitions: alignment FSM states and default word/comma values.
package phy_defs;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

    localparam int         DEF_WIDTH = 8;
    localparam logic [7:0] DEF_COMMA = 8'hBC;

endpackage

// File: rtl/serial_paralelo_phy_rx_align_comma_detect.sv
// Serial shift register with comma compare on the next-state word.
module phy_comma_detect
    import phy_defs::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(DEF_COMMA)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    output logic [WIDTH-1:0] nxt,
    output logic             match
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Compare against the word including the bit sampled this cycle.
    always_comb begin
        nxt     = {shreg_q[WIDTH-2:0], data_in};
        shreg_d = nxt;
        match   = (nxt == COMMA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shreg_q <= '0;
        else        shreg_q <= shreg_d;
    end

endmodule

// File: rtl/serial_paralelo_phy_rx_align.sv
// Serial-to-parallel receiver: comma hunt, multi-comma lock, loss-of-lock on misaligned commas.
module serial_paralelo_phy_rx_align
    import phy_defs::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 3
) (
    input  logic             clk_32f,
    input  logic             default_values,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             word_valid,
    output logic             is_comma,
    output logic             active,
    output logic             idle_out,
    output logic [1:0]       sync_state
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(LOSS_COUNT + 1);

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] LOCK_C   = CW'(LOCK_COUNT);
    localparam logic [CW-1:0] LOCK_M1  = CW'(LOCK_COUNT - 1);
    localparam logic [EW-1:0] LOSS_M1  = EW'(LOSS_COUNT - 1);

    logic [WIDTH-1:0] nxt;
    logic             match;
    logic             boundary;

    sync_state_e      state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
    logic [EW-1:0]    err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             word_valid_q, word_valid_d;
    logic             is_comma_q, is_comma_d;
    logic             active_q, active_d;
    logic             idle_out_q, idle_out_d;

    phy_comma_detect #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_comma_detect (
        .clk     (clk_32f),
        .rst_n   (default_values),
        .data_in (data_in),
        .nxt     (nxt),
        .match   (match)
    );

    assign boundary = (bit_cnt_q == BIT_LAST);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = boundary ? '0 : bit_cnt_q + BW'(1);
        comma_cnt_d  = comma_cnt_q;
        err_cnt_d    = err_cnt_q;
        data_out_d   = data_out_q;
        word_valid_d = 1'b0;
        active_d     = active_q;

        case (state_q)
            HUNT: begin
                if (match) begin
                    bit_cnt_d    = '0;
                    comma_cnt_d  = CW'(1);
                    data_out_d   = nxt;
                    word_valid_d = 1'b1;
                    if (LOCK_COUNT == 1) begin
                        state_d   = LOCKED;
                        active_d  = 1'b1;
                        err_cnt_d = '0;
                    end else begin
                        state_d = SYNC;
                    end
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (match) begin
                        comma_cnt_d  = (comma_cnt_q == LOCK_C) ? comma_cnt_q : comma_cnt_q + CW'(1);
                        data_out_d   = nxt;
                        word_valid_d = 1'b1;
                        if (comma_cnt_q == LOCK_M1) begin
                            state_d   = LOCKED;
                            active_d  = 1'b1;
                            err_cnt_d = '0;
                        end
                    end else begin
                        state_d     = HUNT;
                        comma_cnt_d = '0;
                    end
                end else if (match) begin
                    // A comma off the tentative grid means we guessed the wrong phase.
                    bit_cnt_d    = '0;
                    comma_cnt_d  = CW'(1);
                    data_out_d   = nxt;
                    word_valid_d = 1'b1;
                end
            end
            LOCKED: begin
                if (boundary) begin
                    data_out_d   = nxt;
                    word_valid_d = 1'b1;
                    if (match) err_cnt_d = '0;
                end else if (match) begin
                    if (err_cnt_q == LOSS_M1) begin
                        state_d     = HUNT;
                        active_d    = 1'b0;
                        err_cnt_d   = '0;
                        bit_cnt_d   = '0;
                        comma_cnt_d = '0;
                    end else begin
                        err_cnt_d = err_cnt_q + EW'(1);
                    end
                end
            end
            default: begin
                state_d     = HUNT;
                active_d    = 1'b0;
                comma_cnt_d = '0;
                err_cnt_d   = '0;
            end
        endcase

        is_comma_d = (data_out_d == COMMA);
        idle_out_d = active_d && !is_comma_d;
    end

    always_ff @(posedge clk_32f or negedge default_values) begin
        if (!default_values) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            comma_cnt_q  <= '0;
            err_cnt_q    <= '0;
            data_out_q   <= '0;
            word_valid_q <= 1'b0;
            is_comma_q   <= 1'b0;
            active_q     <= 1'b0;
            idle_out_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            comma_cnt_q  <= comma_cnt_d;
            err_cnt_q    <= err_cnt_d;
            data_out_q   <= data_out_d;
            word_valid_q <= word_valid_d;
            is_comma_q   <= is_comma_d;
            active_q     <= active_d;
            idle_out_q   <= idle_out_d;
        end
    end

    assign data_out   = data_out_q;
    assign word_valid = word_valid_q;
    assign is_comma   = is_comma_q;
    assign active     = active_q;
    assign idle_out   = idle_out_q;
    assign sync_state = state_q;

endmodule

// File: tb/tb_serial_paralelo_phy_rx_align.sv
// Directed bench: default 8-bit/0xBC instance plus a 10-bit/0x17C, LOCK_COUNT=2 instance.
module tb_serial_paralelo_phy_rx_align;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din2 = 1'b0;

    logic [7:0] dout;
    logic       wv, isc, act, idl;
    logic [1:0] st;

    logic [9:0] dout2;
    logic       wv2, isc2, act2, idl2;
    logic [1:0] st2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_paralelo_phy_rx_align dut (
        .clk_32f        (clk),
        .default_values (rst_n),
        .data_in        (din),
        .data_out       (dout),
        .word_valid     (wv),
        .is_comma       (isc),
        .active         (act),
        .idle_out       (idl),
        .sync_state     (st)
    );

    serial_paralelo_phy_rx_align #(
        .WIDTH      (10),
        .COMMA      (10'h17C),
        .LOCK_COUNT (2),
        .LOSS_COUNT (3)
    ) dut2 (
        .clk_32f        (clk),
        .default_values (rst_n),
        .data_in        (din2),
        .data_out       (dout2),
        .word_valid     (wv2),
        .is_comma       (isc2),
        .active         (act2),
        .idle_out       (idl2),
        .sync_state     (st2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit1(input logic b);
        @(negedge clk);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic word1(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) bit1(w[i]);
    endtask

    task automatic word2(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            din2 = w[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din   = 1'b0;
        din2  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lock1();
        do_reset();
        for (int k = 0; k < 4; k++) word1(8'hBC);
    endtask

    initial begin
        // ---- Reset mid-stream, then lock on 4 aligned commas
        do_reset();
        word1(8'hBC);
        word1(8'hBC);
        chk("pre_reset_state", 16'(st), 16'd1);
        chk("pre_reset_data", 16'(dout), 16'h00BC);
        bit1(1'b1); bit1(1'b0); bit1(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data_out", 16'(dout), 16'h0000);
        chk("rst_word_valid", 16'(wv), 16'd0);
        chk("rst_is_comma", 16'(isc), 16'd0);
        chk("rst_active", 16'(act), 16'd0);
        chk("rst_idle_out", 16'(idl), 16'd0);
        chk("rst_sync_state", 16'(st), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        word1(8'hBC);
        chk("bc1_state", 16'(st), 16'd1);
        chk("bc1_valid", 16'(wv), 16'd1);
        chk("bc1_is_comma", 16'(isc), 16'd1);
        word1(8'hBC);
        word1(8'hBC);
        chk("bc3_state", 16'(st), 16'd1);
        chk("bc3_active", 16'(act), 16'd0);
        word1(8'hBC);
        chk("bc4_state", 16'(st), 16'd2);
        chk("bc4_active", 16'(act), 16'd1);
        chk("bc4_idle", 16'(idl), 16'd0);

        // ---- Misaligned start: 3 stray bits, 4 commas, payload 0x5A
        do_reset();
        bit1(1'b0); bit1(1'b1); bit1(1'b0);
        for (int k = 0; k < 4; k++) word1(8'hBC);
        chk("mis_active", 16'(act), 16'd1);
        word1(8'h5A);
        chk("mis_data", 16'(dout), 16'h005A);
        chk("mis_valid", 16'(wv), 16'd1);
        chk("mis_idle", 16'(idl), 16'd1);
        chk("mis_is_comma", 16'(isc), 16'd0);
        bit1(1'b0);
        chk("mis_valid_drop", 16'(wv), 16'd0);

        // ---- SYNC break on a non-comma boundary word
        do_reset();
        word1(8'hBC);
        word1(8'hBC);
        chk("brk_sync", 16'(st), 16'd1);
        word1(8'h33);
        chk("brk_state", 16'(st), 16'd0);
        chk("brk_no_valid", 16'(wv), 16'd0);
        chk("brk_active", 16'(act), 16'd0);
        chk("brk_data_hold", 16'(dout), 16'h00BC);

        // ---- Loss of lock: 3 commas at a 3-bit offset
        lock1();
        bit1(1'b0); bit1(1'b0); bit1(1'b0);
        word1(8'hBC);
        chk("loss_det1_active", 16'(act), 16'd1);
        word1(8'hBC);
        chk("loss_det2_active", 16'(act), 16'd1);
        chk("loss_det2_state", 16'(st), 16'd2);
        word1(8'hBC);
        chk("loss_det3_active", 16'(act), 16'd0);
        chk("loss_det3_state", 16'(st), 16'd0);
        chk("loss_det3_idle", 16'(idl), 16'd0);

        // ---- Error counter cleared by an aligned comma
        lock1();
        bit1(1'b0); bit1(1'b0); bit1(1'b0);
        word1(8'hBC);
        word1(8'hBC);
        chk("clr_err2_active", 16'(act), 16'd1);
        for (int k = 0; k < 5; k++) bit1(1'b0);
        word1(8'hBC);
        chk("clr_aligned_data", 16'(dout), 16'h00BC);
        chk("clr_aligned_comma", 16'(isc), 16'd1);
        bit1(1'b0); bit1(1'b0); bit1(1'b0);
        word1(8'hBC);
        chk("clr_err1b_active", 16'(act), 16'd1);
        word1(8'hBC);
        chk("clr_err2b_active", 16'(act), 16'd1);
        chk("clr_err2b_state", 16'(st), 16'd2);

        // ---- 10-bit instance, comma 0x17C, lock after 2 commas
        do_reset();
        word2(10'h17C);
        chk("w10_c1_state", 16'(st2), 16'd1);
        word2(10'h17C);
        chk("w10_c2_state", 16'(st2), 16'd2);
        chk("w10_c2_active", 16'(act2), 16'd1);
        word2(10'h2AA);
        chk("w10_data", 16'(dout2), 16'h02AA);
        chk("w10_valid", 16'(wv2), 16'd1);
        chk("w10_idle", 16'(idl2), 16'd1);
        chk("w10_is_comma", 16'(isc2), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_phy_rx_align.md
Name: serial_paralelo_phy_rx_align

Overview:
- Parametrised serial-to-parallel receiver for the PHY link, clocked at clk_32f.
- Performs comma-based word alignment and builds lock over several commas, then delivers aligned WIDTH-bit words with a valid strobe.
- Drops lock after repeated misaligned commas and re-hunts automatically.
- Sits between the serial line and the parallel RX datapath. Successor to the fixed 8-bit/0xBC converter.

Parameters:
- WIDTH, 8, word width in bits; legal range 4..16.
- COMMA, 8'hBC, alignment/idle word value, WIDTH bits wide.
- LOCK_COUNT, 4, consecutive boundary-aligned commas needed to declare lock; minimum 1.
- LOSS_COUNT, 3, consecutive misaligned comma detections that force loss of lock; minimum 1.

Ports:
- clk_32f  input  1  serial bit clock; all state updates on its rising edge.
- default_values  input  1  asynchronous active-low reset. Low forces every register to its default immediately. Release is sampled on clk_32f.
- data_in  input  1  serial bit, MSB of each word first.
- data_out  output  WIDTH  last completed aligned word.
- word_valid  output  1  one-cycle pulse when data_out is updated.
- is_comma  output  1  qualifies data_out == COMMA; registered together with data_out.
- active  output  1  link locked.
- idle_out  output  1  registered: active and data_out != COMMA (payload present).
- sync_state  output  2  current FSM state, for debug.

Behaviour:
- Reset (default_values low): data_out=0, word_valid=0, is_comma=0, active=0, idle_out=0, sync_state=HUNT. Shift register, bit counter, comma counter and error counter all 0.
- Shift register: nxt = {shreg[WIDTH-2:0], data_in}; shreg<=nxt every cycle outside reset. All comparisons use nxt, so a word is visible one edge after its last bit is sampled.
- Bit counter bit_cnt counts 0..WIDTH-1 and wraps. A boundary is the cycle where bit_cnt==WIDTH-1.
- FSM encoding: HUNT=0, SYNC=1, LOCKED=2. Value 3 is unused and recovers to HUNT.
- HUNT:
  - Check nxt==COMMA at every bit position.
  - On match: bit_cnt<=0, comma_cnt<=1, data_out<=COMMA, word_valid=1, is_comma=1.
  - Go to LOCKED if LOCK_COUNT==1, else to SYNC.
- SYNC:
  - Boundary with nxt==COMMA: comma_cnt++, emit word. If comma_cnt+1==LOCK_COUNT, go to LOCKED and set active=1.
  - Boundary with nxt!=COMMA: go to HUNT, comma_cnt<=0, no word emitted.
  - Off-boundary nxt==COMMA: realign with bit_cnt<=0, comma_cnt<=1, emit COMMA.
- LOCKED:
  - Every boundary emits nxt on data_out with word_valid=1.
  - A boundary comma clears err_cnt.
  - An off-boundary nxt==COMMA increments err_cnt; alignment is kept.
  - When err_cnt+1==LOSS_COUNT: go to HUNT, active<=0, err_cnt<=0, bit_cnt<=0.
- Simultaneous events:
  - In LOCKED a boundary comma has priority over error counting, since only one position matches per cycle.
  - A reset edge mid-word discards the partial word.
- Saturation:
  - comma_cnt saturates at LOCK_COUNT.
  - err_cnt is $clog2(LOSS_COUNT+1) bits and never wraps.
- idle_out, is_comma and active update on the same edge as data_out. word_valid is low on all non-emitting cycles.

Decomposition:
- Shared package/include file phy_defs: FSM state constants (HUNT/SYNC/LOCKED), default COMMA 8'hBC, default WIDTH.
- One natural sub-module: phy_comma_detect. It holds the shift register plus the equality compare and outputs nxt and match; it is reused by the TX-side loopback checker.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: hold default_values low mid-stream, then release and send 4x 0xBC on boundaries. Required: all outputs 0 during reset; active=1 on the edge after the 4th BC's last bit; sync_state 0->1->2.
- Misaligned start: 3 random bits then BC,BC,BC,BC,0x5A. Required: alignment to the first BC; data_out=0x5A with word_valid and idle_out=1, is_comma=0.
- SYNC break: BC,BC,0x33. Required: return to HUNT at the 0x33 boundary; no word_valid for 0x33; active stays 0.
- Loss of lock: lock, then inject 3 BC patterns at 3-bit offset (LOSS_COUNT=3). Required: active falls at the 3rd detection; sync_state=0.
- Error clear: lock, 2 misaligned BC, 1 aligned BC, 2 misaligned BC. Required: active stays 1 throughout.
- Parametrised instance WIDTH=10, COMMA=10'h17C, LOCK_COUNT=2: send 2 commas then 0x2AA. Required: data_out=10'h2AA with idle_out=1.
